pipe_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage pipelined CPU. It detects load-use hazards, applies branch/jump flushes and freezes the pipe while data memory is busy. It drives the write-enable and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps saturating performance counters. Sits beside the datapath, with inputs taken from the IF/ID, ID/EX and EX/MEM registers.

---
 rtl/pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Stall/flush controller for the 5-stage pipeline. It detects load-use
// hazards, squashes younger instructions on taken branches and jumps,
// freezes every stage while data memory is busy, and halts the pipe after
// too many consecutive busy cycles.
//
// Ports:
//   clk_i, rst_n                  clock (rising edge), async active-low reset
//   if_id_rs_i, if_id_rt_i        source fields of the instruction in ID
//   if_id_uses_rt_i               ID instruction actually reads rt
//   id_ex_memread_i, id_ex_rt_i   load in EX and its destination register
//   jump_i                        jump decoded in ID
//   branch_taken_i                taken branch resolved in EX/MEM
//   mem_busy_i                    data memory not ready this cycle
//   *_write_o                     pipeline register / PC load enables
//   *_flush_o                     pipeline register clears (bubbles)
//   halted_o                      controller is in HALT
//   stall_cnt_o, flush_cnt_o      saturating event counters
//   wait_cnt_o                    current run of consecutive busy cycles
//   fsm_state_o                   debug view of the controller state
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [4:0]       if_id_rs_i,
    input  logic [4:0]       if_id_rt_i,
    input  logic             if_id_uses_rt_i,
    input  logic             id_ex_memread_i,
    input  logic [4:0]       id_ex_rt_i,
    input  logic             jump_i,
    input  logic             branch_taken_i,
    input  logic             mem_busy_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             id_ex_write_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] wait_cnt_o,
    output logic [1:0]       fsm_state_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_MWAIT = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] wait_inc;
    logic             load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // $0 is never a real load destination, so it can never cause a stall.
    assign load_use = id_ex_memread_i && (id_ex_rt_i != 5'd0) &&
                      ((id_ex_rt_i == if_id_rs_i) ||
                       (if_id_uses_rt_i && (id_ex_rt_i == if_id_rt_i)));

    assign wait_inc = wait_cnt_q + 1'b1;

    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        id_ex_write_o  = 1'b1;
        ex_mem_write_o = 1'b1;
        mem_wb_write_o = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        halted_o       = 1'b0;
        state_d        = state_q;
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        wait_cnt_d     = wait_cnt_q;

        if (state_q == ST_HALT) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_write_o = 1'b0;
            mem_wb_write_o = 1'b0;
            halted_o       = 1'b1;
        end else if (mem_busy_i) begin
            // Full freeze: a branch sitting in EX/MEM is held and resolves on
            // the first non-busy cycle.
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_write_o = 1'b0;
            mem_wb_write_o = 1'b0;
            wait_cnt_d     = sat_inc(wait_cnt_q);
            state_d        = (wait_inc == WAIT_LIM) ? ST_HALT : ST_MWAIT;
        end else begin
            wait_cnt_d = '0;
            state_d    = ST_RUN;
            if (branch_taken_i) begin
                // Branch squashes the younger instructions, so a coincident
                // load-use stall or jump is not acted on or counted.
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
                flush_cnt_d    = sat_inc(flush_cnt_q);
            end else if (load_use) begin
                pc_write_o    = 1'b0;
                if_id_write_o = 1'b0;
                id_ex_flush_o = 1'b1;
                stall_cnt_d   = sat_inc(stall_cnt_q);
            end else if (jump_i) begin
                if_id_flush_o = 1'b1;
                flush_cnt_d   = sat_inc(flush_cnt_q);
            end
        end

        // Hold the whole pipe quiet while reset is asserted.
        if (!rst_n) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_write_o = 1'b0;
            mem_wb_write_o = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_flush_o  = 1'b0;
            ex_mem_flush_o = 1'b0;
            halted_o       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign wait_cnt_o  = wait_cnt_q;
    assign fsm_state_o = state_q;

endmodule
